// File: rtl/ex_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_divider_pkg
//  Description : Shared definitions for the iterative divider: ALU function
//                codes, controller state encoding and result constants.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_divider_pkg;

   // ALU function codes understood by the divider (shared system encoding)
   localparam logic [4:0] ALU_DIV  = 5'h0C;
   localparam logic [4:0] ALU_DIVU = 5'h0D;
   localparam logic [4:0] ALU_REM  = 5'h0E;
   localparam logic [4:0] ALU_REMU = 5'h0F;

   // Result returned for a request carrying an unsupported function code
   localparam logic [31:0] RES_ILL      = 32'hbaad_beef;
   localparam logic [31:0] RES_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN      = 32'h8000_0000;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   // True for any of the four function codes this unit implements
   function automatic logic is_div_op(input logic [4:0] func);
      return (func == ALU_DIV) || (func == ALU_DIVU) ||
             (func == ALU_REM) || (func == ALU_REMU);
   endfunction

endpackage : ex_divider_pkg
`default_nettype wire

// File: rtl/ex_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_divider_if
//  Description : Request/result handshake bundle between the execute stage
//                (master) and the divider (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_divider_if;

   logic        in_vld;
   logic        in_rdy;
   logic [4:0]  in_func;
   logic [31:0] in_opa;
   logic [31:0] in_opb;
   logic        flush;
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_res;
   logic        out_ill;

   modport master (
      output in_vld, in_func, in_opa, in_opb, flush, out_rdy,
      input  in_rdy, out_vld, out_res, out_ill
   );

   modport slave (
      input  in_vld, in_func, in_opa, in_opb, flush, out_rdy,
      output in_rdy, out_vld, out_res, out_ill
   );

endinterface : ex_divider_if
`default_nettype wire

// File: rtl/ex_divider.sv
`default_nettype none
// ============================================================================
//  Module      : ex_divider
//  Description : 32-bit iterative restoring divider (DIV/DIVU/REM/REMU).
//                One quotient bit per cycle over 32 CALC cycles, a single
//                sign-fixup cycle, and a one-cycle fast path for divide by
//                zero, signed overflow and unsupported function codes.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_divider
   import ex_divider_pkg::*;
(
   input  wire              clk,
   input  wire              rst,      // asynchronous, active-low
   ex_divider_if.slave      bus
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d;        // dividend shifts out, quotient shifts in
   logic [31:0] rem_q, rem_d;        // partial remainder
   logic [31:0] dvs_q, dvs_d;        // divisor magnitude
   logic [31:0] res_q, res_d;        // final result presented in DONE
   logic        ill_q, ill_d;
   logic        op_rem_q, op_rem_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;

   // Request-side decode of the operands presented on the bus
   logic        req_signed;
   logic        req_rem;
   logic        opa_neg;
   logic        opb_neg;
   logic [31:0] opa_mag;
   logic [31:0] opb_mag;
   logic [32:0] trial;

   // Decode the incoming request and form the operand magnitudes
   always_comb begin
      req_signed = (bus.in_func == ALU_DIV) || (bus.in_func == ALU_REM);
      req_rem    = (bus.in_func == ALU_REM) || (bus.in_func == ALU_REMU);
      opa_neg    = req_signed && bus.in_opa[31];
      opb_neg    = req_signed && bus.in_opb[31];
      opa_mag    = opa_neg ? (32'd0 - bus.in_opa) : bus.in_opa;
      opb_mag    = opb_neg ? (32'd0 - bus.in_opb) : bus.in_opb;
   end

   // Next-state and datapath update for the divider controller
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      res_d     = res_q;
      ill_d     = ill_q;
      op_rem_d  = op_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      // Shift the next dividend bit into the remainder and try to subtract
      trial     = {rem_q, quo_q[31]} - {1'b0, dvs_q};

      case (state_q)
         S_IDLE: begin
            if (bus.in_vld && !bus.flush) begin
               ill_d = 1'b0;
               if (!is_div_op(bus.in_func)) begin
                  res_d   = RES_ILL;
                  ill_d   = 1'b1;
                  state_d = S_DONE;
               end else if (bus.in_opb == 32'd0) begin
                  res_d   = req_rem ? bus.in_opa : RES_ALL_ONES;
                  state_d = S_DONE;
               end else if (req_signed && (bus.in_opa == INT_MIN) &&
                            (bus.in_opb == RES_ALL_ONES)) begin
                  res_d   = req_rem ? 32'd0 : INT_MIN;
                  state_d = S_DONE;
               end else begin
                  quo_d     = opa_mag;
                  dvs_d     = opb_mag;
                  rem_d     = 32'd0;
                  cnt_d     = 5'd0;
                  op_rem_d  = req_rem;
                  neg_quo_d = opa_neg ^ opb_neg;
                  neg_rem_d = opa_neg;
                  state_d   = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (!trial[32]) begin
               rem_d = trial[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = {rem_q[30:0], quo_q[31]};
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (op_rem_q) begin
               res_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
            end else begin
               res_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush abandons whatever is in progress, including an undelivered result
      if (bus.flush) begin
         state_d = S_IDLE;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         quo_q     <= 32'd0;
         rem_q     <= 32'd0;
         dvs_q     <= 32'd0;
         res_q     <= 32'd0;
         ill_q     <= 1'b0;
         op_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         res_q     <= res_d;
         ill_q     <= ill_d;
         op_rem_q  <= op_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   // Outputs: result fields are zero unless a result is being presented
   always_comb begin
      bus.in_rdy  = (state_q == S_IDLE) && rst;
      bus.out_vld = (state_q == S_DONE);
      bus.out_res = (state_q == S_DONE) ? res_q : 32'd0;
      bus.out_ill = (state_q == S_DONE) && ill_q;
   end

endmodule : ex_divider
`default_nettype wire

// File: tb/tb_ex_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_divider
//  Description : Directed self-checking bench for ex_divider.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_divider;
   import ex_divider_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   ex_divider_if bus_if ();

   ex_divider u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, wait for the result, check it and retire it
   task automatic run_op(input string tag, input logic [4:0] func,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ill,
                         input int exp_lat);
      int n;
      bus_if.in_vld  = 1'b1;
      bus_if.in_func = func;
      bus_if.in_opa  = a;
      bus_if.in_opb  = b;
      tick();                     // acceptance edge
      bus_if.in_vld  = 1'b0;
      bus_if.in_func = 5'h00;     // later input changes must not matter
      bus_if.in_opa  = 32'h1234_5678;
      bus_if.in_opb  = 32'd0;
      n = 1;
      while (!bus_if.out_vld && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_res"}, bus_if.out_res, exp_res);
      check({tag, "_ill"}, {31'd0, bus_if.out_ill}, {31'd0, exp_ill});
      bus_if.out_rdy = 1'b1;
      tick();
      bus_if.out_rdy = 1'b0;
      check({tag, "_rdy_after"}, {31'd0, bus_if.in_rdy}, 32'd1);
   endtask

   initial begin
      int   n;
      logic ok;
      n_checks = 0;
      n_pass   = 0;
      rst            = 1'b0;
      bus_if.in_vld  = 1'b0;
      bus_if.in_func = 5'h00;
      bus_if.in_opa  = 32'd0;
      bus_if.in_opb  = 32'd0;
      bus_if.flush   = 1'b0;
      bus_if.out_rdy = 1'b0;

      // Reset state
      tick();
      check("rst_in_rdy",  {31'd0, bus_if.in_rdy},  32'd0);
      check("rst_out_vld", {31'd0, bus_if.out_vld}, 32'd0);
      check("rst_out_res", bus_if.out_res, 32'd0);
      check("rst_out_ill", {31'd0, bus_if.out_ill}, 32'd0);
      rst = 1'b1;
      tick();
      check("post_rst_in_rdy", {31'd0, bus_if.in_rdy}, 32'd1);

      // Normal path
      run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
      run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2,  1'b0, 34);
      run_op("div_m7_2",   ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
      run_op("rem_m7_2",   ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("rem_7_m2",   ALU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 34);
      run_op("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("div_min_2",  ALU_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 34);

      // Fast path
      run_op("div_5_0",    ALU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
      run_op("remu_5_0",   ALU_REMU, 32'd5, 32'd0, 32'd5, 1'b0, 1);
      run_op("div_ovf",    ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
      run_op("rem_ovf",    ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

      // Back-pressure: result held while out_rdy stays low
      bus_if.in_vld  = 1'b1;
      bus_if.in_func = ALU_DIVU;
      bus_if.in_opa  = 32'd100;
      bus_if.in_opb  = 32'd7;
      tick();
      bus_if.in_vld  = 1'b0;
      n = 1;
      while (!bus_if.out_vld && n < 100) begin
         tick();
         n++;
      end
      check("stall_lat", n, 34);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (bus_if.out_vld !== 1'b1 || bus_if.out_res !== 32'd14 || bus_if.in_rdy !== 1'b0) ok = 1'b0;
         tick();
      end
      check("stall_stable", {31'd0, ok}, 32'd1);
      bus_if.out_rdy = 1'b1;
      tick();
      bus_if.out_rdy = 1'b0;
      check("stall_release_rdy", {31'd0, bus_if.in_rdy}, 32'd1);

      // Flush together with in_vld in IDLE must not accept
      bus_if.in_vld  = 1'b1;
      bus_if.flush   = 1'b1;
      tick();
      bus_if.in_vld  = 1'b0;
      bus_if.flush   = 1'b0;
      check("flush_idle_rdy", {31'd0, bus_if.in_rdy}, 32'd1);

      // Flush mid-CALC
      bus_if.in_vld  = 1'b1;
      bus_if.in_func = ALU_DIVU;
      bus_if.in_opa  = 32'd1000;
      bus_if.in_opb  = 32'd3;
      tick();
      bus_if.in_vld  = 1'b0;
      n = 1;
      while (n < 15) begin
         tick();
         n++;
      end
      bus_if.flush = 1'b1;
      tick();
      bus_if.flush = 1'b0;
      check("flush_calc_rdy", {31'd0, bus_if.in_rdy}, 32'd1);
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (bus_if.out_vld !== 1'b0) ok = 1'b0;
         tick();
      end
      check("flush_no_vld", {31'd0, ok}, 32'd1);
      run_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 34);

      // Reset asserted mid-CALC
      bus_if.in_vld  = 1'b1;
      bus_if.in_func = ALU_DIV;
      bus_if.in_opa  = 32'd77;
      bus_if.in_opb  = 32'd5;
      tick();
      bus_if.in_vld  = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b0;
      #1;
      check("midrst_in_rdy",  {31'd0, bus_if.in_rdy},  32'd0);
      check("midrst_out_vld", {31'd0, bus_if.out_vld}, 32'd0);
      check("midrst_out_res", bus_if.out_res, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("midrst_rdy_after", {31'd0, bus_if.in_rdy}, 32'd1);
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (bus_if.out_vld !== 1'b0) ok = 1'b0;
         tick();
      end
      check("midrst_no_vld", {31'd0, ok}, 32'd1);

      // Unsupported function code
      run_op("ill_1f", 5'h1F, 32'd10, 32'd2, 32'hbaad_beef, 1'b1, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_ex_divider
`default_nettype wire

// File: doc/ex_divider.md
EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_vld, input, 1 bit: divide request valid.
REQ-004 SHALL have port in_rdy, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port in_func, input, 5 bits: operation code, one of ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
REQ-006 SHALL have port in_opa, input, 32 bits: dividend.
REQ-007 SHALL have port in_opb, input, 32 bits: divisor.
REQ-008 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-009 SHALL have port out_vld, output, 1 bit: result valid.
REQ-010 SHALL have port out_rdy, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_res, output, 32 bits: quotient or remainder.
REQ-012 SHALL have port out_ill, output, 1 bit: request carried an unsupported func code.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-014 SHALL assert in_rdy only in IDLE; acceptance = in_vld & in_rdy & !flush at a clock edge.
REQ-015 SHALL latch func and operands on acceptance; later input changes have no effect on the operation.
REQ-016 SHALL, for DIV/REM, divide the magnitudes of the operands; for DIVU/REMU, treat operands as unsigned.
REQ-017 SHALL resolve the quotient one bit per cycle by restoring division: 32 CALC cycles, driven by a 5-bit iteration counter.
REQ-018 SHALL, in FIX (1 cycle), negate the quotient if the operand signs differ (signed ops only) and give the remainder the dividend's sign.
REQ-019 SHALL present out_vld exactly 34 cycles after the acceptance edge on the normal path (IDLE->CALC x32->FIX->DONE).
REQ-020 SHALL take a fast path (IDLE->DONE, out_vld 1 cycle after acceptance) for divide-by-zero, signed overflow and unsupported func.
REQ-021 SHALL, for divide-by-zero: DIV/DIVU quotient = 32'hFFFF_FFFF; REM/REMU remainder = dividend.
REQ-022 SHALL, for signed overflow (0x8000_0000 / 0xFFFF_FFFF): DIV = 0x8000_0000; REM = 0.
REQ-023 SHALL, for an unsupported func, return out_res = 32'hbaadbeef with out_ill = 1; out_ill = 0 otherwise.
REQ-024 SHALL hold out_vld, out_res and out_ill stable in DONE until out_rdy = 1, then move to IDLE on that edge.
REQ-025 SHALL, on flush in any state, return to IDLE at the next edge with out_vld = 0 and no result delivered; flush with in_vld in IDLE SHALL NOT accept.
REQ-026 SHALL drive out_res = 0 and out_ill = 0 whenever out_vld = 0.

Reset
REQ-027 SHALL, while rst = 0, force state IDLE, counter 0, all datapath registers 0, out_vld = 0, out_res = 0, out_ill = 0, in_rdy = 0.
REQ-028 SHALL discard an in-flight operation when rst asserts mid-operation; in_rdy = 1 on the first edge after rst deasserts.

Structure
REQ-029 SHALL take ALU_DIV/DIVU/REM/REMU codes from the shared sys_defs.vh definitions; the state enum typedef belongs in the shared package.
REQ-030 SHALL be a single module with no sub-modules; the ex_stage integration (stall on !in_rdy / !out_vld) is outside this block.

Verification
REQ-031 SHALL cover DIVU 100/7 -> out_vld at cycle 34, out_res = 14; REMU 100/7 -> 2.
REQ-032 SHALL cover DIV -7/2 -> 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
REQ-033 SHALL cover DIV 5/0 -> 0xFFFF_FFFF at cycle 1; REMU 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000; REM -> 0.
REQ-034 SHALL cover out_rdy held low 10 cycles after out_vld -> out_res stable and in_rdy = 0 throughout; in_rdy = 1 the cycle after out_rdy.
REQ-035 SHALL cover flush at CALC cycle 15 -> IDLE next cycle, no out_vld; a new DIVU 9/3 then returns 3.
REQ-036 SHALL cover rst asserted mid-CALC -> outputs 0 immediately; func 5'h1F -> out_res = 0xbaadbeef, out_ill = 1.
